disp_sched: RTL and testbench

DISP_SCHED -- requirements
Module: disp_sched

---
 rtl/disp_sched_if.sv | 30 +++
 rtl/disp_sched.sv | 133 +++++++++++++
 tb/tb_disp_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/disp_sched_if.sv
// Display scheduler bus: channel inputs from the producer side, strobed
// digit outputs and a debug view of the scheduler state from the display side.
interface disp_sched_if #(
  parameter int NCH  = 2,
  parameter int NDIG = 8,
  parameter int SELW = 3
);
  logic [SELW-1:0]        sel;
  logic                   tick;
  logic [NCH*NDIG*8-1:0]  ch_data;
  logic [NCH*NDIG-1:0]    ch_en;
  logic [NCH*NDIG-1:0]    ch_flash;
  // Strobe semantics: seg_valid is active-low and one-hot-zero; a 0 in bit d
  // means seg_o holds digit d's pattern for the whole slot. All ones means no
  // digit is lit and seg_o is 8'hFF. There is no back-pressure on this bus.
  logic [NDIG-1:0]        seg_valid;
  logic [7:0]             seg_o;
  logic [SELW-1:0]        active_ch;
  logic                   frame_start;
  logic                   state_dbg;

  modport master (
    output sel, tick, ch_data, ch_en, ch_flash,
    input  seg_valid, seg_o, active_ch, frame_start, state_dbg
  );
  modport slave (
    input  sel, tick, ch_data, ch_en, ch_flash,
    output seg_valid, seg_o, active_ch, frame_start, state_dbg
  );
endinterface

// File: rtl/disp_sched.sv
// Multiplexed 7-segment scan scheduler: frame-snapshotted channel data,
// one blank frame on every channel switch, per-digit enable and flash.
module disp_sched #(
  parameter int NCH      = 2,
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 50000,
  parameter int SELW     = 3
) (
  input logic        clk,
  input logic        rst,
  disp_sched_if.slave bus
);
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DIGW = $clog2(NDIG);
  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} state_t;

  state_t            state;
  logic [SELW-1:0]   sel_meta, sel_s, pending, active_ch, snap_ch;
  logic [DIVW-1:0]   div;
  logic [DIGW-1:0]   dig;
  logic              phase, frame_start;
  logic [NDIG*8-1:0] snap_data, nxt_data;
  logic [NDIG-1:0]   snap_en, snap_flash, nxt_en, nxt_flash;
  logic [NDIG-1:0]   seg_valid, strobe;
  logic [7:0]        seg_o, dig_pat;
  logic              dig_on, tc, wrap, sel_ok;

  assign tc     = (div == DIVW'(SCAN_DIV-1));
  assign wrap   = tc && (dig == DIGW'(NDIG-1));
  assign sel_ok = ({1'b0, sel_s} < NCH_L);
  // Leaving BLANK loads pending into active_ch on the same edge, so the
  // snapshot must already follow pending.
  assign snap_ch = (state == BLANK) ? pending : active_ch;
  assign strobe  = ~(NDIG'(1) << dig);

  always_comb begin
    nxt_data  = '0;
    nxt_en    = '0;
    nxt_flash = '0;
    for (int c = 0; c < NCH; c++) begin
      if (snap_ch == SELW'(c)) begin
        nxt_data  = bus.ch_data[c*NDIG*8 +: NDIG*8];
        nxt_en    = bus.ch_en[c*NDIG +: NDIG];
        nxt_flash = bus.ch_flash[c*NDIG +: NDIG];
      end
    end
  end

  always_comb begin
    dig_pat = 8'hFF;
    dig_on  = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (dig == DIGW'(d)) begin
        dig_pat = snap_data[d*8 +: 8];
        dig_on  = snap_en[d] && !(snap_flash[d] && phase);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_meta    <= '0;
      sel_s       <= '0;
      div         <= '0;
      dig         <= '0;
      phase       <= 1'b0;
      state       <= BLANK;
      pending     <= '0;
      active_ch   <= '0;
      snap_data   <= '0;
      snap_en     <= '0;
      snap_flash  <= '0;
      seg_valid   <= '1;
      seg_o       <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      sel_meta    <= bus.sel;
      sel_s       <= sel_meta;
      frame_start <= wrap;
      if (bus.tick) phase <= ~phase;

      if (tc) begin
        div <= '0;
        dig <= wrap ? '0 : dig + 1'b1;
      end else begin
        div <= div + 1'b1;
      end

      case (state)
        BLANK: begin
          if (sel_ok) pending <= sel_s;
          if (wrap) begin
            state     <= SCAN;
            active_ch <= pending;
          end
        end
        SCAN: begin
          if (wrap && sel_ok && (sel_s != active_ch)) begin
            state   <= BLANK;
            pending <= sel_s;
          end
        end
        default: state <= BLANK;
      endcase

      if (wrap) begin
        snap_data  <= nxt_data;
        snap_en    <= nxt_en;
        snap_flash <= nxt_flash;
      end

      // div==0 is the cycle after terminal count: dig, state and snapshot
      // already describe the new slot.
      if (div == '0) begin
        if (state == SCAN && dig_on) begin
          seg_valid <= strobe;
          seg_o     <= dig_pat;
        end else begin
          seg_valid <= '1;
          seg_o     <= 8'hFF;
        end
      end
    end
  end

  assign bus.seg_valid   = seg_valid;
  assign bus.seg_o       = seg_o;
  assign bus.active_ch   = active_ch;
  assign bus.frame_start = frame_start;
  assign bus.state_dbg   = (state == SCAN);
endmodule

// File: tb/tb_disp_sched.sv
// Randomized bench for disp_sched: a frame-level reference model fills an
// expected queue per clock; a negedge monitor pops and compares.
module tb_disp_sched;
  localparam int NCH = 2, NDIG = 4, SCAN_DIV = 4, SELW = 1;
  localparam int FR = NDIG * SCAN_DIV;
  localparam int EW = 2 + SELW + NDIG + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  disp_sched_if #(.NCH(NCH), .NDIG(NDIG), .SELW(SELW)) bus();
  disp_sched #(.NCH(NCH), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  bit upd_en = 1'b0;
  int mcyc = 0;

  // Reference model state, indexed by edges since reset release / frame number.
  int t;
  int tcnt[0:1023];
  bit                fr_blank[0:63];
  logic [SELW-1:0]   fr_act[0:63];
  logic [NDIG*8-1:0] fr_data[0:63];
  logic [NDIG-1:0]   fr_en[0:63];
  logic [NDIG-1:0]   fr_flash[0:63];
  bit                m_blank;
  logic [SELW-1:0]   m_act;

  function automatic logic [EW-1:0] cur_out();
    return {bus.frame_start, bus.state_dbg, bus.active_ch, bus.seg_valid, bus.seg_o};
  endfunction

  task automatic check(string name, logic [EW-1:0] got, logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got fs=%b scan=%b act=%0d sv=%b seg=%h, required fs=%b scan=%b act=%0d sv=%b seg=%h",
               name, got[EW-1], got[EW-2], got[NDIG+8 +: SELW], got[8 +: NDIG], got[7:0],
               exp[EW-1], exp[EW-2], exp[NDIG+8 +: SELW], exp[8 +: NDIG], exp[7:0]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mcyc++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_q cyc %0d: got an output with no expected entry", mcyc);
      end else begin
        check($sformatf("out cyc %0d", mcyc), cur_out(), exp_q.pop_front());
      end
    end
  end

  function automatic void model_reset();
    t = 0;
    tcnt[0] = 0;
    m_blank = 1'b1;
    m_act = '0;
    fr_blank[0] = 1'b1;
    fr_act[0] = '0;
    fr_data[0] = '0;
    fr_en[0] = '0;
    fr_flash[0] = '0;
  endfunction

  // Channel rules at a frame boundary; sel and channel data are stable here.
  function automatic void frame_boundary(int f);
    if (m_blank) begin
      m_act = bus.sel;
      m_blank = 1'b0;
    end else if (bus.sel != m_act) begin
      m_blank = 1'b1;
    end
    fr_blank[f] = m_blank;
    fr_act[f]   = m_act;
    fr_data[f]  = bus.ch_data[int'(m_act)*NDIG*8 +: NDIG*8];
    fr_en[f]    = bus.ch_en[int'(m_act)*NDIG +: NDIG];
    fr_flash[f] = bus.ch_flash[int'(m_act)*NDIG +: NDIG];
  endfunction

  function automatic logic [EW-1:0] exp_at(int tt);
    int fo = (tt - 1) / FR;
    int d  = ((tt - 1) / SCAN_DIV) % NDIG;
    int ts = tt - ((tt - 1) % SCAN_DIV);
    int fa = tt / FR;
    bit ph = (tcnt[ts-1] % 2) == 1;
    logic [NDIG-1:0] sv = '1;
    logic [7:0] so = 8'hFF;
    if (!fr_blank[fo] && fr_en[fo][d] && !(fr_flash[fo][d] && ph)) begin
      sv[d] = 1'b0;
      so = fr_data[fo][d*8 +: 8];
    end
    return {(tt % FR) == 0, !fr_blank[fa], fr_act[fa], sv, so};
  endfunction

  task automatic step();
    t++;
    tcnt[t] = tcnt[t-1] + int'(bus.tick);
    if (t % FR == 0) frame_boundary(t / FR);
    exp_q.push_back(exp_at(t));
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic frame_update(int f);
    case (f)
      1: bus.sel = 1'b1;
      4: begin
        bus.ch_en[1] = 1'b0;
        bus.sel = 1'b0;
      end
      6: bus.ch_data[31:0] = 32'h8877_6655;
      default: begin
        if (f >= 7) begin
          if ($urandom_range(0, 3) == 0) bus.sel = ~bus.sel;
          for (int i = 0; i < NCH*NDIG; i++) begin
            bus.ch_data[i*8 +: 8] = 8'($urandom_range(0, 255));
            bus.ch_en[i]    = ($urandom_range(0, 3) != 0);
            bus.ch_flash[i] = ($urandom_range(0, 3) == 0);
          end
        end
      end
    endcase
  endtask

  task automatic run_cycles(int n);
    for (int i = 0; i < n; i++) begin
      if (upd_en && ((t + 1) % FR) == FR/2) frame_update((t + 1) / FR);
      bus.tick = ($urandom_range(0, 5) == 0);
      step();
    end
  endtask

  task automatic load_defaults();
    bus.sel = '0;
    bus.tick = 1'b0;
    bus.ch_data = {32'hA3A2_A1A0, 32'h4433_2211};
    bus.ch_en = '1;
    bus.ch_flash = '0;
    bus.ch_flash[NDIG + 2] = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    mon_en = 1'b1;
    upd_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] rst_val;
    bit found;
    rst_val = {1'b0, 1'b0, {SELW{1'b0}}, {NDIG{1'b1}}, 8'hFF};
    load_defaults();
    repeat (3) @(negedge clk);
    #1;
    check("reset_hold", cur_out(), rst_val);

    release_reset();
    run_cycles(20 * FR);

    // Let the display settle on one channel, then reset during digit 2 of SCAN.
    upd_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 * FR && !found; i++) begin
      bus.tick = 1'b0;
      step();
      if (!fr_blank[(t - 1) / FR] && ((t - 1) / SCAN_DIV) % NDIG == 2 && (t - 1) % SCAN_DIV == 1)
        found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL seek_scan_digit2: got no SCAN digit-2 slot within %0d cycles, required one", 4 * FR);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset", cur_out(), rst_val);
    @(negedge clk);
    #1;
    check("reset_held", cur_out(), rst_val);

    load_defaults();
    release_reset();
    run_cycles(8 * FR);
    mon_en = 1'b0;

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
